quiz_ctrl_param: RTL and testbench

- Parametrised answer-entry and grading controller for the push-button quiz panel; next generation of the fixed 10-question, 4-option controller.
- Sits between the debounced key pulses and the display/score path.
- Adds over the fixed version:
  - configurable question count, option count, points per question and answer key
  - previous-question navigation and a clear/restart key
  - explicit FSM with serial grading and a busy flag
  - a correct-answer count output

---
 rtl/quiz_pkg.sv | 25 ++
 rtl/quiz_ctrl_param_if.sv | 28 ++
 rtl/quiz_grader.sv | 57 +++++
 rtl/quiz_ctrl_param.sv | 117 +++++++++++
 tb/tb_quiz_ctrl_param.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/quiz_pkg.sv
// Shared types and elaboration helpers for the parametrised quiz controller.
package quiz_pkg;

  typedef enum logic [1:0] {
    ANSWER = 2'd0,
    GRADE  = 2'd1,
    DONE   = 2'd2
  } quiz_state_e;

  function automatic int qclog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Ranges the datapath widths were sized for; anything outside can overflow a field.
  function automatic bit params_ok(input int nQ, input int nOpt, input int aw,
                                   input int pw, input int pts);
    return (nQ >= 2) && (nQ <= 15) && (nOpt >= 2) && (nOpt <= 7) &&
           (aw < 31) && ((1 << aw) > nOpt) && (pts >= 1) &&
           (pw < 31) && ((1 << pw) > nQ * pts);
  endfunction

endpackage

// File: rtl/quiz_ctrl_param_if.sv
// Key pulses in, answer/score status out, between the key debouncer and the display path.
interface quiz_ctrl_param_if #(
  parameter int N_Q = 10,
  parameter int AW  = 3,
  parameter int PW  = 8
);
  logic              key_sel;
  logic              key_next;
  logic              key_prev;
  logic              key_submit;
  logic              key_clear;
  logic [N_Q*AW-1:0] Ans;
  logic [3:0]        Num;
  logic [PW-1:0]     Point;
  logic [3:0]        Correct;
  logic              Busy;
  logic              End;

  modport master (
    output key_sel, key_next, key_prev, key_submit, key_clear,
    input  Ans, Num, Point, Correct, Busy, End
  );

  modport slave (
    input  key_sel, key_next, key_prev, key_submit, key_clear,
    output Ans, Num, Point, Correct, Busy, End
  );
endinterface

// File: rtl/quiz_grader.sv
// Serial grader: walks the questions one per cycle, counting answers that match the key.
module quiz_grader
  import quiz_pkg::*;
#(
  parameter int N_Q = 10,
  parameter int AW  = 3
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              start,
  input  logic              abort,
  input  logic [N_Q*AW-1:0] Ans,
  input  logic [N_Q*AW-1:0] KEY,
  output logic              done,
  output logic [3:0]        correct
);
  localparam int IW = qclog2(N_Q);

  logic          runQ;
  logic [IW-1:0] idxQ;
  logic [3:0]    cntQ;
  logic          hit;

  // NOTE: every signal assigned in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    hit = 1'b0;
    for (int q = 0; q < N_Q; q++) begin
      if (idxQ == IW'(q))
        hit = (Ans[q*AW +: AW] != '0) && (Ans[q*AW +: AW] == KEY[q*AW +: AW]);
    end
  end

  // done and correct are combinational so the caller can latch the total on the last grading edge.
  assign done    = runQ && (idxQ == IW'(N_Q - 1));
  assign correct = cntQ + 4'(hit);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      runQ <= 1'b0;
      idxQ <= '0;
      cntQ <= '0;
    end else if (abort) begin
      runQ <= 1'b0;
      idxQ <= '0;
      cntQ <= '0;
    end else if (start) begin
      runQ <= 1'b1;
      idxQ <= '0;
      cntQ <= '0;
    end else if (runQ) begin
      cntQ <= correct;
      if (done) runQ <= 1'b0;
      else      idxQ <= idxQ + IW'(1);
    end
  end

endmodule

// File: rtl/quiz_ctrl_param.sv
// Parametrised quiz panel controller: answer entry and navigation, then serial grading to a score.
module quiz_ctrl_param
  import quiz_pkg::*;
#(
  parameter int N_Q   = 10,
  parameter int N_OPT = 4,
  parameter int PTS   = 10,
  parameter int AW    = 3,
  parameter int PW    = 8,
  parameter logic [N_Q*AW-1:0] KEY = {3'd1, 3'd1, 3'd1, 3'd4, 3'd4,
                                      3'd1, 3'd2, 3'd4, 3'd1, 3'd2}
) (
  input logic              CLK,
  input logic              RSTn,
  quiz_ctrl_param_if.slave bus
);
  if (!params_ok(N_Q, N_OPT, AW, PW, PTS)) begin : gBadParams
    $fatal(1, "quiz_ctrl_param: parameter set out of supported range");
  end

  localparam logic [3:0]    NUM_LAST = 4'(N_Q);
  localparam logic [AW-1:0] OPT_LAST = AW'(N_OPT);

  quiz_state_e       stateQ;
  logic [N_Q*AW-1:0] ansQ;
  logic [3:0]        numQ;
  logic [PW-1:0]     pointQ;
  logic [3:0]        correctQ;
  logic              busyQ;
  logic              endQ;

  logic       gradeStart;
  logic       gradeDone;
  logic [3:0] gradeCorrect;

  // Clear outranks submit, so a simultaneous clear never launches a grading pass.
  assign gradeStart = (stateQ == ANSWER) && bus.key_submit && !bus.key_clear;

  quiz_grader #(
    .N_Q (N_Q),
    .AW  (AW)
  ) uGrader (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .start   (gradeStart),
    .abort   (bus.key_clear),
    .Ans     (ansQ),
    .KEY     (KEY),
    .done    (gradeDone),
    .correct (gradeCorrect)
  );

  // Answer codes step 0 -> 1 .. N_OPT and wrap back to 1, never to unanswered.
  function automatic logic [AW-1:0] stepCode(input logic [AW-1:0] c);
    return (c == OPT_LAST) ? AW'(1) : c + AW'(1);
  endfunction

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      // NOTE: answers are individual flops rather than a memory, so they take the reset value directly.
      stateQ   <= ANSWER;
      ansQ     <= '0;
      numQ     <= 4'd1;
      pointQ   <= '0;
      correctQ <= '0;
      busyQ    <= 1'b0;
      endQ     <= 1'b0;
    end else if (bus.key_clear) begin
      stateQ   <= ANSWER;
      ansQ     <= '0;
      numQ     <= 4'd1;
      pointQ   <= '0;
      correctQ <= '0;
      busyQ    <= 1'b0;
      endQ     <= 1'b0;
    end else begin
      case (stateQ)
        ANSWER: begin
          if (bus.key_submit) begin
            stateQ <= GRADE;
            busyQ  <= 1'b1;
          end else begin
            for (int q = 0; q < N_Q; q++) begin
              if (bus.key_sel && (numQ == 4'(q + 1)))
                ansQ[q*AW +: AW] <= stepCode(ansQ[q*AW +: AW]);
            end
            case ({bus.key_next, bus.key_prev})
              2'b10:   numQ <= (numQ == NUM_LAST) ? 4'd1 : numQ + 4'd1;
              2'b01:   numQ <= (numQ == 4'd1) ? NUM_LAST : numQ - 4'd1;
              default: numQ <= numQ;
            endcase
          end
        end
        GRADE: begin
          if (gradeDone) begin
            stateQ   <= DONE;
            busyQ    <= 1'b0;
            endQ     <= 1'b1;
            correctQ <= gradeCorrect;
            pointQ   <= PW'(gradeCorrect) * PW'(PTS);
          end
        end
        DONE:    stateQ <= DONE;
        default: stateQ <= ANSWER;
      endcase
    end
  end

  assign bus.Ans     = ansQ;
  assign bus.Num     = numQ;
  assign bus.Point   = pointQ;
  assign bus.Correct = correctQ;
  assign bus.Busy    = busyQ;
  assign bus.End     = endQ;

endmodule

// File: tb/tb_quiz_ctrl_param.sv
// Directed bench for quiz_ctrl_param: default 10-question instance plus a 4-question instance.
module tb_quiz_ctrl_param;

  localparam logic [4:0] SEL    = 5'b00001;
  localparam logic [4:0] NEXT   = 5'b00010;
  localparam logic [4:0] PREV   = 5'b00100;
  localparam logic [4:0] SUBMIT = 5'b01000;
  localparam logic [4:0] CLEAR  = 5'b10000;

  logic CLK  = 1'b0;
  logic RSTn = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int keyA[10] = '{2, 1, 4, 2, 1, 4, 4, 1, 1, 1};
  logic [29:0] expAns;

  quiz_ctrl_param_if #(.N_Q(10), .AW(3), .PW(8)) b ();
  quiz_ctrl_param_if #(.N_Q(4),  .AW(3), .PW(8)) s ();

  quiz_ctrl_param dutA (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (b)
  );

  quiz_ctrl_param #(
    .N_Q   (4),
    .N_OPT (3),
    .PTS   (5),
    .AW    (3),
    .PW    (8),
    .KEY   ({3'd3, 3'd3, 3'd3, 3'd3})
  ) dutB (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (s)
  );

  // Key bits: {clear, submit, prev, next, sel}; held high across exactly one rising edge.
  task automatic press(input logic [4:0] k);
    @(negedge CLK);
    {b.key_clear, b.key_submit, b.key_prev, b.key_next, b.key_sel} = k;
    @(negedge CLK);
    {b.key_clear, b.key_submit, b.key_prev, b.key_next, b.key_sel} = '0;
  endtask

  task automatic pressS(input logic [4:0] k);
    @(negedge CLK);
    {s.key_clear, s.key_submit, s.key_prev, s.key_next, s.key_sel} = k;
    @(negedge CLK);
    {s.key_clear, s.key_submit, s.key_prev, s.key_next, s.key_sel} = '0;
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    repeat (2) @(negedge CLK);
    checks++; if (b.Ans !== 30'd0) begin errors++; $display("FAIL reset_ans: got %0h want 0", b.Ans); end
    checks++; if (b.Num !== 4'd1) begin errors++; $display("FAIL reset_num: got %0d want 1", b.Num); end
    checks++; if (b.Point !== 8'd0) begin errors++; $display("FAIL reset_point: got %0d want 0", b.Point); end
    checks++; if (b.Correct !== 4'd0) begin errors++; $display("FAIL reset_correct: got %0d want 0", b.Correct); end
    checks++; if ({b.Busy, b.End} !== 2'b00) begin errors++; $display("FAIL reset_flags: busy/end got %b want 00", {b.Busy, b.End}); end
    RSTn = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_select();
    repeat (3) press(SEL);
    checks++; if (b.Ans[2:0] !== 3'd3) begin errors++; $display("FAIL sel_x3: got %0d want 3", b.Ans[2:0]); end
    checks++; if (b.Num !== 4'd1) begin errors++; $display("FAIL sel_num: got %0d want 1", b.Num); end
    repeat (2) press(SEL);
    checks++; if (b.Ans[2:0] !== 3'd1) begin errors++; $display("FAIL sel_wrap: got %0d want 1", b.Ans[2:0]); end
  endtask

  task automatic test_nav();
    press(PREV);
    checks++; if (b.Num !== 4'd10) begin errors++; $display("FAIL prev_wrap: got %0d want 10", b.Num); end
    press(NEXT);
    checks++; if (b.Num !== 4'd1) begin errors++; $display("FAIL next_wrap: got %0d want 1", b.Num); end
    press(NEXT);
    checks++; if (b.Num !== 4'd2) begin errors++; $display("FAIL next_step: got %0d want 2", b.Num); end
    press(NEXT | PREV);
    checks++; if (b.Num !== 4'd2) begin errors++; $display("FAIL next_prev_same: got %0d want 2", b.Num); end
    press(PREV);
    // Q1 holds 1 here; select with next updates Q1 then moves on.
    press(SEL | NEXT);
    checks++; if (b.Ans[5:0] !== 6'b000_010) begin errors++; $display("FAIL sel_next_ans: got %0h want 02", b.Ans[5:0]); end
    checks++; if (b.Num !== 4'd2) begin errors++; $display("FAIL sel_next_num: got %0d want 2", b.Num); end
    press(SEL | PREV);
    checks++; if (b.Ans[5:0] !== 6'b001_010) begin errors++; $display("FAIL sel_prev_ans: got %0h want 0a", b.Ans[5:0]); end
    checks++; if (b.Num !== 4'd1) begin errors++; $display("FAIL sel_prev_num: got %0d want 1", b.Num); end
  endtask

  task automatic test_full_key();
    press(CLEAR);
    checks++; if ({b.Ans, b.Num} !== {30'd0, 4'd1}) begin errors++; $display("FAIL clear_answer: ans %0h num %0d want 0/1", b.Ans, b.Num); end
    expAns = '0;
    for (int q = 0; q < 10; q++) begin
      expAns[q*3 +: 3] = 3'(keyA[q]);
      repeat (keyA[q]) press(SEL);
      if (q < 9) press(NEXT);
    end
    checks++; if (b.Ans !== expAns) begin errors++; $display("FAIL full_ans: got %0h want %0h", b.Ans, expAns); end
    checks++; if (b.Num !== 4'd10) begin errors++; $display("FAIL full_num: got %0d want 10", b.Num); end
    press(SUBMIT);
    for (int i = 1; i <= 10; i++) begin
      checks++;
      if ({b.Busy, b.End} !== 2'b10) begin
        errors++; $display("FAIL full_busy t+%0d: busy/end got %b want 10", i, {b.Busy, b.End});
      end
      @(negedge CLK);
    end
    checks++; if ({b.Busy, b.End} !== 2'b01) begin errors++; $display("FAIL full_end: busy/end got %b want 01", {b.Busy, b.End}); end
    checks++; if (b.Point !== 8'd100) begin errors++; $display("FAIL full_point: got %0d want 100", b.Point); end
    checks++; if (b.Correct !== 4'd10) begin errors++; $display("FAIL full_correct: got %0d want 10", b.Correct); end
    press(SEL);
    checks++; if (b.Ans !== expAns) begin errors++; $display("FAIL done_sel_frozen: got %0h want %0h", b.Ans, expAns); end
    press(NEXT);
    checks++; if (b.Num !== 4'd10) begin errors++; $display("FAIL done_num_frozen: got %0d want 10", b.Num); end
    press(SUBMIT);
    checks++; if ({b.End, b.Point} !== {1'b1, 8'd100}) begin errors++; $display("FAIL done_submit_ignored: end %b point %0d want 1/100", b.End, b.Point); end
  endtask

  task automatic test_partial();
    press(CLEAR);
    checks++; if ({b.End, b.Point, b.Correct} !== 13'd0) begin errors++; $display("FAIL clear_done: end %b point %0d correct %0d want 0", b.End, b.Point, b.Correct); end
    repeat (2) press(SEL);
    repeat (2) press(NEXT);
    press(SEL);
    press(SUBMIT | SEL);
    checks++; if (b.Busy !== 1'b1) begin errors++; $display("FAIL partial_busy: got %b want 1", b.Busy); end
    repeat (9) @(negedge CLK);
    checks++; if ({b.End, b.Point} !== 9'd0) begin errors++; $display("FAIL partial_hold: end %b point %0d want 0/0", b.End, b.Point); end
    @(negedge CLK);
    checks++; if (b.End !== 1'b1) begin errors++; $display("FAIL partial_end: got %b want 1", b.End); end
    checks++; if (b.Point !== 8'd10) begin errors++; $display("FAIL partial_point: got %0d want 10", b.Point); end
    checks++; if (b.Correct !== 4'd1) begin errors++; $display("FAIL partial_correct: got %0d want 1", b.Correct); end
    checks++; if (b.Ans !== 30'd66) begin errors++; $display("FAIL submit_sel_discard: got %0h want 42", b.Ans); end
  endtask

  task automatic test_clear_mid_grade();
    press(CLEAR);
    repeat (2) press(SEL);
    press(SUBMIT);
    repeat (2) @(negedge CLK);
    checks++; if (b.Busy !== 1'b1) begin errors++; $display("FAIL midgrade_busy: got %b want 1", b.Busy); end
    press(CLEAR);
    checks++; if ({b.Busy, b.End} !== 2'b00) begin errors++; $display("FAIL abort_flags: busy/end got %b want 00", {b.Busy, b.End}); end
    checks++; if ({b.Point, b.Correct} !== 12'd0) begin errors++; $display("FAIL abort_score: point %0d correct %0d want 0", b.Point, b.Correct); end
    checks++; if ({b.Ans, b.Num} !== {30'd0, 4'd1}) begin errors++; $display("FAIL abort_ans: ans %0h num %0d want 0/1", b.Ans, b.Num); end
    press(SEL);
    checks++; if (b.Ans[2:0] !== 3'd1) begin errors++; $display("FAIL abort_answer_state: got %0d want 1", b.Ans[2:0]); end
    repeat (12) @(negedge CLK);
    checks++; if ({b.Busy, b.End} !== 2'b00) begin errors++; $display("FAIL abort_no_done: busy/end got %b want 00", {b.Busy, b.End}); end
  endtask

  task automatic test_small();
    repeat (4) pressS(SEL);
    checks++; if (s.Ans[2:0] !== 3'd1) begin errors++; $display("FAIL small_wrap: got %0d want 1", s.Ans[2:0]); end
    repeat (2) pressS(SEL);
    pressS(NEXT);
    for (int q = 1; q < 4; q++) begin
      repeat (3) pressS(SEL);
      pressS(NEXT);
    end
    checks++; if (s.Ans !== 12'b011_011_011_011) begin errors++; $display("FAIL small_ans: got %0h want 6db", s.Ans); end
    checks++; if (s.Num !== 4'd1) begin errors++; $display("FAIL small_num_wrap: got %0d want 1", s.Num); end
    pressS(SUBMIT);
    repeat (3) @(negedge CLK);
    checks++; if ({s.Busy, s.End} !== 2'b10) begin errors++; $display("FAIL small_t4: busy/end got %b want 10", {s.Busy, s.End}); end
    @(negedge CLK);
    checks++; if ({s.Busy, s.End} !== 2'b01) begin errors++; $display("FAIL small_t5: busy/end got %b want 01", {s.Busy, s.End}); end
    checks++; if (s.Point !== 8'd20) begin errors++; $display("FAIL small_point: got %0d want 20", s.Point); end
    checks++; if (s.Correct !== 4'd4) begin errors++; $display("FAIL small_correct: got %0d want 4", s.Correct); end
  endtask

  task automatic test_reset_mid_grade();
    press(CLEAR);
    repeat (2) press(SEL);
    press(SUBMIT);
    @(negedge CLK);
    #2 RSTn = 1'b0;
    #1;
    checks++; if ({b.Busy, b.End} !== 2'b00) begin errors++; $display("FAIL async_rst_flags: busy/end got %b want 00", {b.Busy, b.End}); end
    checks++; if ({b.Ans, b.Num} !== {30'd0, 4'd1}) begin errors++; $display("FAIL async_rst_ans: ans %0h num %0d want 0/1", b.Ans, b.Num); end
    @(negedge CLK);
    RSTn = 1'b1;
    repeat (12) @(negedge CLK);
    checks++; if ({b.Busy, b.End, b.Point} !== 10'd0) begin errors++; $display("FAIL async_rst_no_resume: busy %b end %b point %0d want 0", b.Busy, b.End, b.Point); end
  endtask

  initial begin
    {b.key_clear, b.key_submit, b.key_prev, b.key_next, b.key_sel} = '0;
    {s.key_clear, s.key_submit, s.key_prev, s.key_next, s.key_sel} = '0;
    test_reset();
    test_select();
    test_nav();
    test_full_key();
    test_partial();
    test_clear_mid_grade();
    test_small();
    test_reset_mid_grade();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
